// File: rtl/core_pkg.sv
// Shared defaults and helpers for the core register file slice.
package core_pkg;

    // Default datapath width in bits.
    localparam int XLEN_DEFAULT = 32;

    // Default register count, including the hard-wired x0.
    localparam int NREG_DEFAULT = 32;

    // Address width needed to select one of n registers (at least 1 bit).
    function automatic int addr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/core_regfile_rdport.sv
// One registered read port: address mux, same-edge write bypass,
// same-edge scoreboard bypass and the output registers.
module core_regfile_rdport
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int AW   = addr_width(NREG)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 re,
    input  logic [AW-1:0]        raddr,
    input  logic [NREG*XLEN-1:0] regs_flat,
    input  logic [NREG-1:0]      busy_q,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [XLEN-1:0]      wr_merged,
    input  logic                 busy_set,
    input  logic [AW-1:0]        busy_addr,
    output logic [XLEN-1:0]      rdata,
    output logic                 rbusy
);

    logic [XLEN-1:0] data_next;
    logic            busy_next;

    // Value the addressed register holds after this edge; x0 is always 0.
    always_comb begin
        data_next = regs_flat[int'(raddr)*XLEN +: XLEN];
        if (we && (waddr == raddr)) begin
            data_next = wr_merged;
        end
        if (raddr == '0) begin
            data_next = '0;
        end
    end

    // Pending flag after this edge: a write clears, a busy set wins over it.
    always_comb begin
        busy_next = busy_q[raddr];
        if (we && (waddr == raddr)) begin
            busy_next = 1'b0;
        end
        if (busy_set && (busy_addr == raddr)) begin
            busy_next = 1'b1;
        end
        if (raddr == '0) begin
            busy_next = 1'b0;
        end
    end

    // Output registers load only when the port is enabled, else hold.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata <= '0;
            rbusy <= 1'b0;
        end else if (re) begin
            rdata <= data_next;
            rbusy <= busy_next;
        end
    end

endmodule

// File: rtl/core_regfile.sv
// Integer register file with byte-strobed writes, NRD registered read
// ports, a per-register pending (busy) scoreboard and the program counter.
module core_regfile
    import core_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    parameter  int NRD  = 2,
    localparam int AW   = addr_width(NREG)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WE,
    input  logic [AW-1:0]       WADDR,
    input  logic [XLEN-1:0]     WDATA,
    input  logic [XLEN/8-1:0]   WSTRB,
    input  logic                BUSY_SET,
    input  logic [AW-1:0]       BUSY_ADDR,
    input  logic [NRD-1:0]      RE,
    input  logic [NRD*AW-1:0]   RADDR,
    output logic [NRD*XLEN-1:0] RDATA,
    output logic [NRD-1:0]      RBUSY,
    input  logic                PC_WE,
    input  logic [XLEN-1:0]     PC_WDATA,
    output logic [XLEN-1:0]     PC
);

    localparam int NBYTES = XLEN / 8;

    logic [XLEN-1:0]      regs [NREG];
    logic [NREG*XLEN-1:0] regs_flat;
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [XLEN-1:0]      wr_merged;
    logic [XLEN-1:0]      wr_old;

    // Byte-lane merge of the write data into the current register contents;
    // with no strobes set this is simply the old value.
    always_comb begin
        wr_old    = regs[WADDR];
        wr_merged = wr_old;
        for (int b = 0; b < NBYTES; b++) begin
            if (WSTRB[b]) begin
                wr_merged[b*8 +: 8] = WDATA[b*8 +: 8];
            end
        end
    end

    // Flatten the array so each read port can mux from a single vector.
    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NREG; r++) begin
            regs_flat[r*XLEN +: XLEN] = regs[r];
        end
    end

    // Storage array: x0 is never written so it stays at its reset value 0.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (WE && (WADDR != '0)) begin
            regs[WADDR] <= wr_merged;
        end
    end

    // Next scoreboard: write clears, busy set applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (WE) begin
            busy_d[WADDR] = 1'b0;
        end
        if (BUSY_SET) begin
            busy_d[BUSY_ADDR] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Program counter: load on PC_WE, hold otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PC <= '0;
        end else if (PC_WE) begin
            PC <= PC_WDATA;
        end
    end

    // Read ports.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        core_regfile_rdport #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_rdport (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .re        (RE[i]),
            .raddr     (RADDR[i*AW +: AW]),
            .regs_flat (regs_flat),
            .busy_q    (busy_q),
            .we        (WE),
            .waddr     (WADDR),
            .wr_merged (wr_merged),
            .busy_set  (BUSY_SET),
            .busy_addr (BUSY_ADDR),
            .rdata     (RDATA[i*XLEN +: XLEN]),
            .rbusy     (RBUSY[i])
        );
    end

endmodule

// File: doc/core_regfile.md
CORE_REGFILE -- requirements
Module: core_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter NREG, default 32, register count including x0; power of two, 2..64.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have derived constant AW = log2(NREG), address width.
REQ-005 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-006 SHALL have port RST_N  in  1  reset; asynchronous and active-low.
REQ-007 SHALL have port WE  in  1  write enable.
REQ-008 SHALL have port WADDR  in  AW  write address.
REQ-009 SHALL have port WDATA  in  XLEN  write data.
REQ-010 SHALL have port WSTRB  in  XLEN/8  byte-lane strobes; bit k enables byte k.
REQ-011 SHALL have port BUSY_SET  in  1  mark a destination pending.
REQ-012 SHALL have port BUSY_ADDR  in  AW  address marked pending.
REQ-013 SHALL have port RE  in  NRD  per-port read enable.
REQ-014 SHALL have port RADDR  in  NRD*AW  read addresses; port i at [i*AW +: AW].
REQ-015 SHALL have port RDATA  out  NRD*XLEN  registered read data; port i at [i*XLEN +: XLEN].
REQ-016 SHALL have port RBUSY  out  NRD  registered pending flag per read port.
REQ-017 SHALL have port PC_WE  in  1  program-counter load.
REQ-018 SHALL have port PC_WDATA  in  XLEN  program-counter load value.
REQ-019 SHALL have port PC  out  XLEN  program counter.

Function
REQ-020 SHALL commit a write at the rising edge on which WE=1, with no extra enable-delay stage.
REQ-021 SHALL replace only the bytes whose WSTRB bit is 1; all other bytes SHALL keep their old value.
REQ-022 SHALL treat WSTRB=0 with WE=1 as a no-op for data, but SHALL still apply the busy clear in REQ-027.
REQ-023 SHALL ignore writes to address 0; x0 SHALL read as 0 and never report busy.
REQ-024 SHALL, for each port i with RE[i]=1, load RDATA port i at the edge with the value of register RADDR(i), giving 1-cycle latency.
REQ-025 SHALL bypass a same-edge write to the same address: RDATA SHALL equal the merged post-write value.
REQ-026 SHALL hold RDATA port i and RBUSY[i] unchanged while RE[i]=0.
REQ-027 SHALL keep an NREG-bit busy scoreboard: BUSY_SET sets bit BUSY_ADDR; WE clears bit WADDR.
REQ-028 SHALL let set win when set and clear target the same address on the same edge.
REQ-029 SHALL compute RBUSY[i] from the post-update scoreboard, with the same bypass rule as data.
REQ-030 SHALL allow all NRD ports to read the same address simultaneously, each with identical results.
REQ-031 SHALL load PC with PC_WDATA when PC_WE=1 and hold it otherwise.
REQ-032 SHALL make the register array, scoreboard and PC each update at most once per edge, with no combinational path from any input to any output.

Reset
REQ-033 SHALL, while RST_N=0, immediately and asynchronously clear all registers, the scoreboard, RDATA, RBUSY and PC to 0.
REQ-034 SHALL discard any write, busy set or PC load that coincides with reset.
REQ-035 SHALL accept operations from the first rising edge after RST_N deasserts.

Structure
REQ-036 SHALL place in shared package core_pkg: the XLEN default, the NREG default, and an address-width helper function.
REQ-037 SHALL implement each read port as sub-module core_regfile_rdport (address mux, write bypass, busy bypass, output register) and instantiate it NRD times.
REQ-038 SHALL keep the storage array, scoreboard and PC in the top module.

Verification
REQ-039 SHALL verify write-then-read: WE=1, WADDR=5, WDATA=0xDEADBEEF, WSTRB=0xF; next cycle RE[0]=1, RADDR0=5 -> RDATA0=0xDEADBEEF one cycle later.
REQ-040 SHALL verify partial write and bypass: with x7=0x11223344, write WDATA=0xAABBCCDD, WSTRB=0x5, while port1 reads x7 in the same cycle -> RDATA1=0x11BB33DD.
REQ-041 SHALL verify x0: write 0xFFFFFFFF to x0, then read on both ports -> 0 and RBUSY=0.
REQ-042 SHALL verify the scoreboard: BUSY_SET on x9, read x9 -> RBUSY=1; BUSY_SET x9 with a same-cycle WE x9 -> still 1; a lone WE x9 -> 0.
REQ-043 SHALL verify hold and PC: RE=0 -> RDATA held despite a changing RADDR; PC_WE with 0x80000000 -> PC=0x80000000 next cycle.
REQ-044 SHALL verify reset mid-operation: assert RST_N=0 between edges while writing -> all outputs 0 immediately; x5 then reads 0.
